clk_div_prog: RTL
=================

# clk_div_prog

Runtime-programmable integer clock divider that generates a registered divided clock, with rise/fall strobes, from the 60 MHz-class system clock. The divide ratio loads through a shadow register and applies only at a period boundary, so the output never glitches or shortens a period. It can also be phase-restarted by a synchronous `sync` input. It replaces the fixed divide-by-10 dividers that feed the NMR pulse-sequencer and ADC timing logic.

## Interface

- `CNT_W`, 16: width of divide ratio and internal counter.
- `DIV_DEFAULT`, 10: ratio after reset. Must satisfy 2 ≤ value ≤ 2^CNT_W−1.

- `clkin`  in  1  system clock. All logic is on the rising edge.
- `rst_n`  in  1  reset. Synchronous, active-low.
- `en`  in  1  run enable. Low holds the divider idle.
- `div_in`  in  CNT_W  requested divide ratio N.
- `div_load`  in  1  single-cycle strobe. Samples `div_in`.
- `sync`  in  1  phase restart strobe.
- `clkout`  out  1  divided clock. Registered.
- `rise_pulse`  out  1  one-`clkin` strobe, coincident with `clkout` 0→1.
- `fall_pulse`  out  1  one-`clkin` strobe, coincident with `clkout` 1→0.
- `div_cur`  out  CNT_W  ratio currently in force.
- `load_ack`  out  1  one-cycle strobe: pending ratio just applied.
- `load_err`  out  1  one-cycle strobe: rejected load (`div_in` < 2).

## Operation

- State:
  - `cnt[CNT_W]`
  - `div_cur`
  - `shadow[CNT_W]`
  - `pending`
- H(N) = N − floor(N/2), the high time. Each period is H cycles high, then floor(N/2) cycles low. Example: N=7 gives 4 high, 3 low.
- Reset, at an edge with `rst_n`=0, sets:
  - `cnt` = DIV_DEFAULT−1
  - `div_cur` = DIV_DEFAULT
  - `shadow` = DIV_DEFAULT, `pending` = 0
  - all outputs 0
- Reset mid-operation: same values at that edge. Any pending load is discarded.
- Idle (`en`=0):
  - `cnt` = `div_cur`−1.
  - `clkout` driven 0 at the next edge. `fall_pulse` fires if it was 1.
  - A pending load applies at the next edge, with `load_ack`.
- Run (`en`=1):
  - Boundary when `cnt` = `div_cur`−1: `cnt` ← 0.
  - Otherwise `cnt` ← `cnt`+1.
  - `clkout` ← (`cnt`_next < H(`div_next`)), where `div_next` is the ratio in force after this edge.
- Boundary with `pending`=1:
  - `div_cur` ← `shadow`, `pending` ← 0.
  - `load_ack` = 1 for that cycle.
  - The new ratio governs the period beginning at that edge.
- Load handling:
  - `div_load`=1 with `div_in` ≥ 2: `shadow` ← `div_in`, `pending` ← 1.
  - Repeated loads before a boundary: last one wins, one ack.
  - `div_load`=1 with `div_in` < 2: `load_err` next cycle. Shadow, pending and ratio unchanged.
- Load coinciding with a boundary edge:
  - The boundary applies the old `shadow`, or nothing if none was pending.
  - The new value is captured and applies at the following boundary.
- `sync`=1 with `en`=1:
  - Treated as a forced boundary: `cnt` ← 0, pending load applied, `clkout` ← 1.
  - `rise_pulse` fires only if `clkout` was 0.
  - Overrides a natural boundary in the same cycle (identical effect).
- `sync` with `en`=0: ignored.
- Strobes:
  - `rise_pulse`/`fall_pulse` are registered alongside `clkout`: high exactly in the cycle where `clkout` differs from its previous value in that direction.
  - Never both high at once.

## Timing

- `en` sampled 1 at edge E0 from idle: `clkout` and `rise_pulse` go 1 at E0. The first period starts at E0.
- Steady state: rising edges of `clkout` are exactly N `clkin` cycles apart. `fall_pulse` follows `rise_pulse` by H(N) cycles.
- Load latency: `div_load` at edge L. The ratio applies at the first boundary strictly after L, at most `div_cur`+1 cycles later.
- `load_err`: 1 cycle after the strobe.
- `sync` at edge S: `clkout` high from S. The next natural rise is at S+`div_cur`.
- `en` dropped at edge D: `clkout`=0 from D. No partial-period reuse on re-enable.
- No combinational paths from inputs to outputs.

## Test plan

- Reset, then `en`=1 with default N=10 → `clkout` period 10, high 5 cycles. `rise_pulse` every 10th cycle. `div_cur`=10.
- Load 7 mid-period at cnt=3 → current 10-cycle period completes, then `load_ack` and `div_cur`=7 on the same edge. Subsequent periods are 4 high, 3 low.
- Load 1, then load 0 → `load_err` pulse each time. Period stays 10, `div_cur`=10, no `load_ack`.
- Loads 6 then 12 before a boundary, with one load on the boundary edge itself → only 12 applied at the boundary, one `load_ack`. The boundary-coincident value applies at the next boundary.
- `sync` at cnt=7 with N=10 → `clkout` 1 and `rise_pulse` at that edge (it was low). Next rise 10 cycles later.
- `en` low mid-high-phase, then `rst_n` low for one edge mid-run → `fall_pulse`, `clkout`=0 and counter held. After reset, all outputs 0, `div_cur`=10, and the pending load is discarded.

Source files
------------

// File: rtl/clk_div_prog.sv
`default_nettype none
// ============================================================================
//  Module   : clk_div_prog
//  Purpose  : Runtime-programmable integer clock divider. Produces a registered
//             divided clock plus rise/fall strobes. New divide ratios are held
//             in a shadow register and take effect only at a period boundary,
//             so a period is never glitched or shortened. A sync strobe forces
//             an immediate boundary (phase restart).
//  Revision : 1.0  initial release
// ============================================================================
module clk_div_prog #(
  parameter int CNT_W       = 16,
  parameter int DIV_DEFAULT = 10
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  input  logic             sync,
  output logic             clkout,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] div_cur,
  output logic             load_ack,
  output logic             load_err
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  // Position within the current period, 0 .. div_cur-1.
  logic [CNT_W-1:0] cnt;
  // Requested ratio waiting for the next boundary.
  logic [CNT_W-1:0] shadow;
  logic             pending;

  logic             load_ok;
  logic             load_bad;
  logic             boundary;
  logic             apply;
  logic [CNT_W-1:0] div_next;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] high_time;
  logic             clk_next;
  logic [CNT_W-1:0] shadow_next;
  logic             pending_next;

  // Next-state computation for counter, ratio, shadow and divided clock.
  always_comb begin
    load_ok   = div_load && (div_in >= MIN_DIV);
    load_bad  = div_load && (div_in <  MIN_DIV);

    // A sync strobe is a forced boundary; it has the same effect as a natural one.
    boundary  = en && (sync || (cnt == (div_cur - ONE)));

    // The pending ratio is committed at a boundary, or straight away while idle.
    // It always uses the shadow value from before this edge, so a load landing
    // on the boundary edge waits for the following boundary.
    apply     = pending && (boundary || !en);
    div_next  = apply ? shadow : div_cur;

    // Idle parks the counter at the last count so enabling starts a fresh period.
    if (!en) begin
      cnt_next = div_next - ONE;
    end else if (boundary) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + ONE;
    end

    // High time is the ceiling half of the period; odd ratios spend the extra cycle high.
    high_time = div_next - (div_next >> 1);
    clk_next  = en && (cnt_next < high_time);

    shadow_next  = load_ok ? div_in : shadow;
    pending_next = load_ok || (pending && !apply);
  end

  // State and registered outputs; strobes compare the next clock value with the current one.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      cnt        <= DIV_RST - ONE;
      div_cur    <= DIV_RST;
      shadow     <= DIV_RST;
      pending    <= 1'b0;
      clkout     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      load_ack   <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      div_cur    <= div_next;
      shadow     <= shadow_next;
      pending    <= pending_next;
      clkout     <= clk_next;
      rise_pulse <= clk_next && !clkout;
      fall_pulse <= !clk_next && clkout;
      load_ack   <= apply;
      load_err   <= load_bad;
    end
  end

endmodule
`default_nettype wire
